// File: rtl/core_timer_pkg.sv
// Shared register map and bus helpers for the machine timer block.
// Any block that decodes the timer's register offsets imports this package.
package core_timer_pkg;

  localparam int DATA_W = 32;
  localparam int ADR_W  = 3;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [3:0]       sel;
    word_t            dat;
  } wb_req_t;

  // Word offsets; the byte offset is the word offset times 4.
  localparam logic [ADR_W-1:0] TIMER_MTIME_LO    = 3'd0;
  localparam logic [ADR_W-1:0] TIMER_MTIME_HI    = 3'd1;
  localparam logic [ADR_W-1:0] TIMER_MTIMECMP_LO = 3'd2;
  localparam logic [ADR_W-1:0] TIMER_MTIMECMP_HI = 3'd3;
  localparam logic [ADR_W-1:0] TIMER_MSIP        = 3'd4;

  // Replace only the bytes whose enable is set.
  function automatic word_t byte_merge(input word_t old_w, input word_t new_w,
                                       input logic [3:0] sel);
    word_t merged;
    merged = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_w[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk_i down to the mtime increment rate: tick_o is high for one
// cycle out of every PRESCALE, on the cycle the counter is about to wrap.
module timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt_p0;

  assign tick_o = (cnt_p0 == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_p0 <= '0;
    end else if (tick_o) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + 16'd1;
    end
  end

endmodule

// File: rtl/core_timer.sv
// Machine timer and software-interrupt source for one hart: 64-bit mtime,
// mtimecmp and msip behind a Wishbone-classic slave with single-cycle ack.
module core_timer
  import core_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADR_W-1:0]  wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              timer_int_o,
  output logic              soft_int_o
);

  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;

  logic [63:0] mtime_nxt;
  logic [63:0] mtimecmp_nxt;
  logic        msip_nxt;

  wb_req_t     req_p0;
  logic        req_vld_p0;
  logic        wr_p0;
  word_t       rd_mux_p0;

  logic        ack_p1;
  word_t       rdata_p1;
  logic        tint_p1;
  logic        sint_p1;

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  // ---- p0: request decode and next-state selection ----
  assign req_vld_p0 = wb_cyc_i & wb_stb_i & ~ack_p1;
  assign req_p0     = '{we: wb_we_i, adr: wb_adr_i, sel: wb_sel_i, dat: wb_dat_i};
  assign wr_p0      = req_vld_p0 & req_p0.we;

  always_comb begin
    rd_mux_p0 = '0;
    case (req_p0.adr)
      TIMER_MTIME_LO:    rd_mux_p0 = mtime[31:0];
      TIMER_MTIME_HI:    rd_mux_p0 = mtime[63:32];
      TIMER_MTIMECMP_LO: rd_mux_p0 = mtimecmp[31:0];
      TIMER_MTIMECMP_HI: rd_mux_p0 = mtimecmp[63:32];
      TIMER_MSIP:        rd_mux_p0 = {31'b0, msip};
      default:           rd_mux_p0 = '0;
    endcase
  end

  // A bus write to either half suppresses that cycle's increment entirely,
  // so the untouched half never sees a carry from the written one.
  always_comb begin
    mtime_nxt = mtime;
    if (wr_p0 && req_p0.adr == TIMER_MTIME_LO) begin
      mtime_nxt[31:0] = byte_merge(mtime[31:0], req_p0.dat, req_p0.sel);
    end else if (wr_p0 && req_p0.adr == TIMER_MTIME_HI) begin
      mtime_nxt[63:32] = byte_merge(mtime[63:32], req_p0.dat, req_p0.sel);
    end else if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_nxt = mtimecmp;
    msip_nxt     = msip;
    if (wr_p0 && req_p0.adr == TIMER_MTIMECMP_LO) begin
      mtimecmp_nxt[31:0] = byte_merge(mtimecmp[31:0], req_p0.dat, req_p0.sel);
    end
    if (wr_p0 && req_p0.adr == TIMER_MTIMECMP_HI) begin
      mtimecmp_nxt[63:32] = byte_merge(mtimecmp[63:32], req_p0.dat, req_p0.sel);
    end
    if (wr_p0 && req_p0.adr == TIMER_MSIP && req_p0.sel[0]) begin
      msip_nxt = req_p0.dat[0];
    end
  end

  // ---- p1: architectural state, ack/read data and interrupt outputs ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime    <= '0;
      mtimecmp <= '1;
      msip     <= 1'b0;
      ack_p1   <= 1'b0;
      rdata_p1 <= '0;
      tint_p1  <= 1'b0;
      sint_p1  <= 1'b0;
    end else begin
      mtime    <= mtime_nxt;
      mtimecmp <= mtimecmp_nxt;
      msip     <= msip_nxt;
      ack_p1   <= req_vld_p0;
      rdata_p1 <= req_vld_p0 ? rd_mux_p0 : '0;
      // Compare uses this cycle's register values, not the ones being written.
      tint_p1  <= (mtime >= mtimecmp);
      sint_p1  <= msip;
    end
  end

  assign wb_ack_o    = ack_p1;
  assign wb_dat_o    = rdata_p1;
  assign timer_int_o = tint_p1;
  assign soft_int_o  = sint_p1;

endmodule

// File: tb/tb_core_timer.sv
// Bench for core_timer: two instances (PRESCALE 1 and 4) checked against a
// register-history model where mtime is a linear function of the edge count.
module tb_core_timer;

  localparam longint unsigned P0 = 1;
  localparam longint unsigned P1 = 4;
  localparam int K_MT   = 0;
  localparam int K_CMP  = 1;
  localparam int K_MSIP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc  [2] = '{1'b0, 1'b0};
  logic        stb  [2] = '{1'b0, 1'b0};
  logic        we   [2] = '{1'b0, 1'b0};
  logic [2:0]  adr  [2] = '{3'd0, 3'd0};
  logic [3:0]  sel  [2] = '{4'd0, 4'd0};
  logic [31:0] wdat [2] = '{32'd0, 32'd0};
  logic [31:0] rdat [2];
  logic        ack  [2];
  logic        ti   [2];
  logic        si   [2];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  core_timer #(.PRESCALE(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
    .wb_ack_o(ack[0]), .timer_int_o(ti[0]), .soft_int_o(si[0])
  );

  core_timer #(.PRESCALE(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
    .wb_ack_o(ack[1]), .timer_int_o(ti[1]), .soft_int_o(si[1])
  );

  // Non-reset rising edges since the last reset edge.
  longint unsigned edge_n = 0;
  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  // Each entry: register `kind` of instance `d` holds `v` after edge `e`.
  typedef struct {
    int              d;
    int              kind;
    longint unsigned e;
    logic [63:0]     v;
  } hist_t;
  hist_t hist[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
    end
  endfunction

  function automatic longint unsigned presc(input int d);
    return (d == 0) ? P0 : P1;
  endfunction

  function automatic hist_t find(input int d, input int kind, input longint unsigned n);
    hist_t r;
    r = '{d: d, kind: kind, e: 0, v: 64'd0};
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].d == d && hist[i].kind == kind && hist[i].e <= n) return hist[i];
    end
    return r;
  endfunction

  // mtime ticks on every edge k with k % PRESCALE == 0, except an edge that carried a write.
  function automatic logic [63:0] mt_at(input int d, input longint unsigned n);
    hist_t h;
    h = find(d, K_MT, n);
    return h.v + 64'((n / presc(d)) - (h.e / presc(d)));
  endfunction

  function automatic logic [63:0] cmp_at(input int d, input longint unsigned n);
    hist_t h;
    h = find(d, K_CMP, n);
    return h.v;
  endfunction

  function automatic logic msip_at(input int d, input longint unsigned n);
    hist_t h;
    h = find(d, K_MSIP, n);
    return h.v[0];
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int d = 0; d < 2; d++) begin
      hist.push_back('{d: d, kind: K_MT,   e: 0, v: 64'd0});
      hist.push_back('{d: d, kind: K_CMP,  e: 0, v: '1});
      hist.push_back('{d: d, kind: K_MSIP, e: 0, v: 64'd0});
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  // Interrupt outputs are checked on every cycle against the model.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic exp_ti, exp_si;
        if (edge_n == 0) begin
          exp_ti = 1'b0;
          exp_si = 1'b0;
        end else begin
          exp_ti = (mt_at(d, edge_n - 1) >= cmp_at(d, edge_n - 1));
          exp_si = msip_at(d, edge_n - 1);
        end
        chk($sformatf("timer_int%0d", d), 64'(ti[d]), 64'(exp_ti));
        chk($sformatf("soft_int%0d", d), 64'(si[d]), 64'(exp_si));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
  endtask

  // One Wishbone transfer; reads are compared with the model, writes update it.
  task automatic xfer(input int d, input bit w, input logic [2:0] a, input logic [3:0] s,
                      input logic [31:0] dat, output logic [31:0] rd);
    longint unsigned n0;
    logic [63:0] m, c, ev;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = dat;
    n0 = edge_n;
    @(negedge clk);
    rd = rdat[d];
    chk($sformatf("ack_rise%0d", d), 64'(ack[d]), 64'd1);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    m = mt_at(d, n0);
    c = cmp_at(d, n0);
    if (!w) begin
      case (a)
        3'd0:    ev = {32'd0, m[31:0]};
        3'd1:    ev = {32'd0, m[63:32]};
        3'd2:    ev = {32'd0, c[31:0]};
        3'd3:    ev = {32'd0, c[63:32]};
        3'd4:    ev = {63'd0, msip_at(d, n0)};
        default: ev = 64'd0;
      endcase
      chk($sformatf("read%0d_a%0d", d, a), 64'(rd), ev);
    end else begin
      case (a)
        3'd0: hist.push_back('{d: d, kind: K_MT,  e: n0 + 1, v: {m[63:32], merge(m[31:0], dat, s)}});
        3'd1: hist.push_back('{d: d, kind: K_MT,  e: n0 + 1, v: {merge(m[63:32], dat, s), m[31:0]}});
        3'd2: hist.push_back('{d: d, kind: K_CMP, e: n0 + 1, v: {c[63:32], merge(c[31:0], dat, s)}});
        3'd3: hist.push_back('{d: d, kind: K_CMP, e: n0 + 1, v: {merge(c[63:32], dat, s), c[31:0]}});
        3'd4: if (s[0]) hist.push_back('{d: d, kind: K_MSIP, e: n0 + 1, v: {63'd0, dat[0]}});
        default: ;
      endcase
    end
  endtask

  typedef struct {
    int          d;
    bit          w;
    logic [2:0]  a;
    logic [3:0]  s;
    logic [31:0] dat;
    bit          has_exp;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd;
    bit          found;

    model_reset();

    // Reset defaults, unmapped space and msip byte enables.
    tbl.push_back('{d: 0, w: 0, a: 3'd2, s: 4'hF, dat: 32'h0,        has_exp: 1, exp: 32'hFFFF_FFFF});
    tbl.push_back('{d: 0, w: 0, a: 3'd3, s: 4'hF, dat: 32'h0,        has_exp: 1, exp: 32'hFFFF_FFFF});
    tbl.push_back('{d: 0, w: 0, a: 3'd4, s: 4'hF, dat: 32'h0,        has_exp: 1, exp: 32'h0});
    tbl.push_back('{d: 1, w: 0, a: 3'd3, s: 4'hF, dat: 32'h0,        has_exp: 1, exp: 32'hFFFF_FFFF});
    tbl.push_back('{d: 0, w: 1, a: 3'd5, s: 4'hF, dat: 32'h1234,     has_exp: 0, exp: 32'h0});
    tbl.push_back('{d: 0, w: 0, a: 3'd5, s: 4'hF, dat: 32'h0,        has_exp: 1, exp: 32'h0});
    tbl.push_back('{d: 0, w: 0, a: 3'd7, s: 4'hF, dat: 32'h0,        has_exp: 1, exp: 32'h0});
    tbl.push_back('{d: 0, w: 1, a: 3'd4, s: 4'hF, dat: 32'hFFFF_FFFF, has_exp: 0, exp: 32'h0});
    tbl.push_back('{d: 0, w: 0, a: 3'd4, s: 4'hF, dat: 32'h0,        has_exp: 1, exp: 32'h1});
    tbl.push_back('{d: 0, w: 1, a: 3'd4, s: 4'hE, dat: 32'h0,        has_exp: 0, exp: 32'h0});
    tbl.push_back('{d: 0, w: 0, a: 3'd4, s: 4'hF, dat: 32'h0,        has_exp: 1, exp: 32'h1});
    tbl.push_back('{d: 0, w: 1, a: 3'd4, s: 4'h1, dat: 32'h0,        has_exp: 0, exp: 32'h0});
    tbl.push_back('{d: 0, w: 0, a: 3'd4, s: 4'hF, dat: 32'h0,        has_exp: 1, exp: 32'h0});

    do_reset();
    chk("reset_timer_int", 64'(ti[0]), 64'd0);
    for (int i = 0; i < tbl.size(); i++) begin
      xfer(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].dat, rd);
      if (tbl[i].has_exp) chk($sformatf("tbl%0d", i), 64'(rd), 64'(tbl[i].exp));
    end

    // Prescaler rate: 40 idle cycles at PRESCALE 4.
    do_reset();
    repeat (40) @(negedge clk);
    xfer(1, 0, 3'd0, 4'hF, 32'h0, rd);
    chk("presc_rate", 64'(rd), 64'd10);

    // Compare raise and clear at PRESCALE 1.
    do_reset();
    xfer(0, 1, 3'd3, 4'hF, 32'd0, rd);
    xfer(0, 1, 3'd2, 4'hF, 32'd20, rd);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ti[0]) begin
        found = 1'b1;
        break;
      end
    end
    chk("ti_rise_found", 64'(found), 64'd1);
    if (found) chk("ti_rise_when", mt_at(0, edge_n - 1), 64'd20);
    xfer(0, 1, 3'd3, 4'hF, 32'd1, rd);
    chk("ti_hold_on_ack", 64'(ti[0]), 64'd1);
    @(negedge clk);
    chk("ti_fall", 64'(ti[0]), 64'd0);

    // Carry from low to high half, then full 64-bit wrap.
    xfer(1, 1, 3'd0, 4'hF, 32'hFFFF_FFFE, rd);
    xfer(1, 1, 3'd1, 4'hF, 32'h0, rd);
    repeat (12) @(negedge clk);
    xfer(1, 0, 3'd1, 4'hF, 32'h0, rd);
    chk("carry_hi", 64'(rd), 64'd1);
    xfer(1, 0, 3'd0, 4'hF, 32'h0, rd);
    xfer(1, 1, 3'd1, 4'hF, 32'hFFFF_FFFF, rd);
    xfer(1, 1, 3'd0, 4'hF, 32'hFFFF_FFFF, rd);
    repeat (8) @(negedge clk);
    xfer(1, 0, 3'd1, 4'hF, 32'h0, rd);
    chk("wrap_hi", 64'(rd), 64'd0);
    xfer(1, 0, 3'd0, 4'hF, 32'h0, rd);

    // Byte-enable write colliding with a tick, then the same write cut by reset.
    xfer(0, 1, 3'd0, 4'b0010, 32'h0000_AB00, rd);
    xfer(0, 0, 3'd0, 4'hF, 32'h0, rd);
    xfer(0, 0, 3'd1, 4'hF, 32'h0, rd);
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 3'd0; sel[0] = 4'b0010;
    wdat[0] = 32'h0000_AB00; rst = 1'b1;
    @(negedge clk);
    chk("rst_ack_drop", 64'(ack[0]), 64'd0);
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0; rst = 1'b0;
    model_reset();
    xfer(0, 0, 3'd0, 4'hF, 32'h0, rd);
    chk("rst_no_write", 64'(rd[15:8]), 64'd0);

    // Software interrupt lag and unmapped single-cycle ack.
    xfer(0, 1, 3'd4, 4'hF, 32'hFFFF_FFFF, rd);
    chk("si_lag", 64'(si[0]), 64'd0);
    @(negedge clk);
    chk("si_set", 64'(si[0]), 64'd1);
    xfer(0, 0, 3'd4, 4'hF, 32'h0, rd);
    chk("msip_read", 64'(rd), 64'd1);
    xfer(1, 0, 3'd6, 4'hF, 32'h0, rd);
    chk("unmapped_read", 64'(rd), 64'd0);
    @(negedge clk);
    chk("ack_single", 64'(ack[1]), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      int          d;
      bit          w;
      logic [2:0]  a;
      logic [3:0]  s;
      logic [31:0] dat;
      d   = int'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      a   = 3'($urandom_range(0, 7));
      s   = 4'($urandom);
      dat = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      xfer(d, w, a, s, dat, rd);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
